// File: rtl/l2_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// l2_axi_bridge_if : L2-Mem line request port bundled with AXI4 master channels
// Rev 1.0
// ============================================================================
interface l2_axi_bridge_if #(
  parameter int offset_width = 3
);
  localparam int LW = 32 * (1 << offset_width);

  // L2 read side
  logic [31:0]   addr_l2cache_mem_r;
  logic          l2cache_mem_req_r;
  logic          mem_l2cache_addrOK_r;
  logic [LW-1:0] din_mem_l2cache;
  logic          mem_l2cache_dataOK;
  logic          l2cache_mem_rdy;
  // L2 write side
  logic [31:0]   addr_l2cache_mem_w;
  logic [LW-1:0] dout_l2cache_mem;
  logic          l2cache_mem_req_w;
  logic          mem_l2cache_addrOK_w;
  logic          l2cache_mem_SUC;
  logic [3:0]    l2cache_mem_wstrb;
  logic [1:0]    l2cache_mem_size;
  // AXI read
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  // AXI write
  logic [31:0]   awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic          bvalid;
  logic          bready;

  modport master (
    input  addr_l2cache_mem_r, l2cache_mem_req_r, l2cache_mem_rdy,
    input  addr_l2cache_mem_w, dout_l2cache_mem, l2cache_mem_req_w,
    input  l2cache_mem_SUC, l2cache_mem_wstrb, l2cache_mem_size,
    input  arready, rdata, rlast, rvalid, awready, wready, bvalid,
    output mem_l2cache_addrOK_r, din_mem_l2cache, mem_l2cache_dataOK,
    output mem_l2cache_addrOK_w,
    output araddr, arlen, arsize, arburst, arvalid, rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output addr_l2cache_mem_r, l2cache_mem_req_r, l2cache_mem_rdy,
    output addr_l2cache_mem_w, dout_l2cache_mem, l2cache_mem_req_w,
    output l2cache_mem_SUC, l2cache_mem_wstrb, l2cache_mem_size,
    output arready, rdata, rlast, rvalid, awready, wready, bvalid,
    input  mem_l2cache_addrOK_r, din_mem_l2cache, mem_l2cache_dataOK,
    input  mem_l2cache_addrOK_w,
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready
  );
endinterface
`default_nettype wire

// File: rtl/l2_axi_bridge.sv
`default_nettype none
// ============================================================================
// l2_axi_bridge : L2-Mem line protocol to AXI4 master, posted one-line write buffer
// Rev 1.0
// ============================================================================
module l2_axi_bridge #(
  parameter int offset_width = 3
) (
  input  wire             clk,
  input  wire             rstn,
  l2_axi_bridge_if.master bus
);
  localparam int LW = 32 * (1 << offset_width);
  localparam int c_line_lsb = offset_width + 2;
  localparam logic [7:0] c_burst_len = 8'((1 << offset_width) - 1);
  localparam logic [offset_width-1:0] c_last_beat = '1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2, R_DONE = 2'd3} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_B = 2'd3} wr_state_t;

  rd_state_t r_rd_state, w_rd_state_nxt;
  wr_state_t r_wr_state, w_wr_state_nxt;

  logic [31:0]             r_rd_addr;
  logic                    r_rd_suc;
  logic [1:0]              r_rd_size;
  logic [offset_width-1:0] r_rd_cnt;
  logic [LW-1:0]           r_rd_line;

  logic [31:0]             r_wb_addr;
  logic [LW-1:0]           r_wb_data;
  logic                    r_wb_suc;
  logic [3:0]              r_wb_strb;
  logic [1:0]              r_wb_size;
  logic [offset_width-1:0] r_wr_cnt;

  logic w_wr_accept, w_rd_accept, w_hazard, w_rd_end, w_wlast;
  logic w_arvalid, w_rready, w_dataok, w_awvalid, w_wvalid, w_bready;

  // A read may not overtake a buffered or same-cycle write to its line.
  assign w_wr_accept = bus.l2cache_mem_req_w && (r_wr_state == W_IDLE);
  assign w_hazard = ((r_wr_state != W_IDLE) &&
                     (bus.addr_l2cache_mem_r[31:c_line_lsb] == r_wb_addr[31:c_line_lsb])) ||
                    (w_wr_accept &&
                     (bus.addr_l2cache_mem_r[31:c_line_lsb] == bus.addr_l2cache_mem_w[31:c_line_lsb]));
  assign w_rd_accept = bus.l2cache_mem_req_r && (r_rd_state == R_IDLE) && !w_hazard;
  assign w_rd_end    = bus.rvalid && (r_rd_suc || bus.rlast);
  assign w_wlast     = (r_wr_state == W_DATA) && (r_wb_suc || (r_wr_cnt == c_last_beat));

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_rd_state <= R_IDLE;
      r_wr_state <= W_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_arvalid      = 1'b0;
    w_rready       = 1'b0;
    w_dataok       = 1'b0;
    case (r_rd_state)
      R_IDLE: if (w_rd_accept) w_rd_state_nxt = R_AR;
      R_AR: begin
        w_arvalid = 1'b1;
        if (bus.arready) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        w_rready = 1'b1;
        if (w_rd_end) w_rd_state_nxt = R_DONE;
      end
      R_DONE: begin
        w_dataok = 1'b1;
        if (bus.l2cache_mem_rdy) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_awvalid      = 1'b0;
    w_wvalid       = 1'b0;
    w_bready       = 1'b0;
    case (r_wr_state)
      W_IDLE: if (w_wr_accept) w_wr_state_nxt = W_AW;
      W_AW: begin
        w_awvalid = 1'b1;
        if (bus.awready) w_wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        w_wvalid = 1'b1;
        if (bus.wready && w_wlast) w_wr_state_nxt = W_B;
      end
      W_B: begin
        w_bready = 1'b1;
        if (bus.bvalid) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Line buffer is cleared on accept so an uncached result has zero upper words.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_rd_addr <= '0;
      r_rd_suc  <= 1'b0;
      r_rd_size <= '0;
      r_rd_cnt  <= '0;
      r_rd_line <= '0;
    end else if (w_rd_accept) begin
      r_rd_addr <= bus.addr_l2cache_mem_r;
      r_rd_suc  <= bus.l2cache_mem_SUC;
      r_rd_size <= bus.l2cache_mem_size;
      r_rd_cnt  <= '0;
      r_rd_line <= '0;
    end else if ((r_rd_state == R_DATA) && bus.rvalid) begin
      r_rd_line[{r_rd_cnt, 5'b0} +: 32] <= bus.rdata;
      if (!w_rd_end) r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_wb_suc  <= 1'b0;
      r_wb_strb <= '0;
      r_wb_size <= '0;
      r_wr_cnt  <= '0;
    end else if (w_wr_accept) begin
      r_wb_addr <= bus.addr_l2cache_mem_w;
      r_wb_data <= bus.dout_l2cache_mem;
      r_wb_suc  <= bus.l2cache_mem_SUC;
      r_wb_strb <= bus.l2cache_mem_wstrb;
      r_wb_size <= bus.l2cache_mem_size;
      r_wr_cnt  <= '0;
    end else if ((r_wr_state == W_DATA) && bus.wready && !w_wlast) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  assign bus.mem_l2cache_addrOK_r = w_rd_accept;
  assign bus.mem_l2cache_addrOK_w = w_wr_accept;
  assign bus.din_mem_l2cache      = r_rd_line;
  assign bus.mem_l2cache_dataOK   = w_dataok;

  assign bus.araddr  = r_rd_suc ? r_rd_addr : {r_rd_addr[31:c_line_lsb], {c_line_lsb{1'b0}}};
  assign bus.arlen   = r_rd_suc ? 8'd0 : c_burst_len;
  assign bus.arsize  = r_rd_suc ? {1'b0, r_rd_size} : 3'd2;
  assign bus.arburst = 2'b01;
  assign bus.arvalid = w_arvalid;
  assign bus.rready  = w_rready;

  assign bus.awaddr  = r_wb_suc ? r_wb_addr : {r_wb_addr[31:c_line_lsb], {c_line_lsb{1'b0}}};
  assign bus.awlen   = r_wb_suc ? 8'd0 : c_burst_len;
  assign bus.awsize  = r_wb_suc ? {1'b0, r_wb_size} : 3'd2;
  assign bus.awburst = 2'b01;
  assign bus.awvalid = w_awvalid;
  assign bus.wdata   = r_wb_data[{r_wr_cnt, 5'b0} +: 32];
  assign bus.wstrb   = r_wb_suc ? r_wb_strb : 4'hF;
  assign bus.wlast   = w_wlast;
  assign bus.wvalid  = w_wvalid;
  assign bus.bready  = w_bready;
endmodule
`default_nettype wire

// File: tb/tb_l2_axi_bridge.sv
`default_nettype none
// ============================================================================
// tb_l2_axi_bridge : directed stimulus with queue scoreboard for l2_axi_bridge
// Rev 1.0
// ============================================================================
module tb_l2_axi_bridge;
  localparam int OW = 3;
  localparam int LW = 32 * (1 << OW);

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  l2_axi_bridge_if #(.offset_width(OW)) bus ();
  l2_axi_bridge #(.offset_width(OW)) dut (.clk(clk), .rstn(rstn), .bus(bus.master));

  typedef struct {logic [31:0] addr; logic [7:0] len; logic [2:0] size;} addr_t;
  typedef struct {logic [31:0] data; logic [3:0] strb; logic last;} wbeat_t;

  addr_t         exp_ar[$];
  addr_t         exp_aw[$];
  wbeat_t        exp_w[$];
  logic [LW-1:0] exp_rd[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no/unexpected handshake, required expected handshake", nm);
  endfunction

  function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < (1 << OW); k++) l[k*32 +: 32] = base + k;
    return l;
  endfunction

  function automatic void push_a(input bit is_w, input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz);
    addr_t e;
    e.addr = a; e.len = len; e.size = sz;
    if (is_w) exp_aw.push_back(e);
    else exp_ar.push_back(e);
  endfunction

  function automatic void push_wline(input logic [31:0] base);
    wbeat_t b;
    for (int k = 0; k < (1 << OW); k++) begin
      b.data = base + k; b.strb = 4'hF; b.last = (k == (1 << OW) - 1);
      exp_w.push_back(b);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT completes a handshake.
  addr_t m_a;
  wbeat_t m_w;
  always @(negedge clk) begin
    if (!rstn) begin
      if (bus.arvalid && bus.arready) begin
        if (exp_ar.size() == 0) fail_now("ar_unexpected");
        else begin
          m_a = exp_ar.pop_front();
          chk("araddr", bus.araddr, m_a.addr);
          chk("arlen", bus.arlen, m_a.len);
          chk("arsize", bus.arsize, m_a.size);
          chk("arburst", bus.arburst, 2'b01);
        end
      end
      if (bus.rvalid) chk("rready_on_beat", bus.rready, 1'b1);
      if (bus.awvalid && bus.awready) begin
        if (exp_aw.size() == 0) fail_now("aw_unexpected");
        else begin
          m_a = exp_aw.pop_front();
          chk("awaddr", bus.awaddr, m_a.addr);
          chk("awlen", bus.awlen, m_a.len);
          chk("awsize", bus.awsize, m_a.size);
          chk("awburst", bus.awburst, 2'b01);
        end
      end
      if (bus.wvalid && bus.wready) begin
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else begin
          m_w = exp_w.pop_front();
          chk("wdata", bus.wdata, m_w.data);
          chk("wstrb", bus.wstrb, m_w.strb);
          chk("wlast", bus.wlast, m_w.last);
        end
      end
      if (bus.mem_l2cache_dataOK && bus.l2cache_mem_rdy) begin
        if (exp_rd.size() == 0) fail_now("rd_unexpected");
        else chk("read_line", bus.din_mem_l2cache, exp_rd.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic l2_read(input logic [31:0] a, input logic suc, input logic [1:0] sz);
    bus.addr_l2cache_mem_r = a; bus.l2cache_mem_SUC = suc; bus.l2cache_mem_size = sz;
    bus.l2cache_mem_req_r = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_l2cache_addrOK_r) begin
        step();
        bus.l2cache_mem_req_r = 1'b0;
        return;
      end
    end
    fail_now("read_accept_timeout");
    bus.l2cache_mem_req_r = 1'b0;
  endtask

  task automatic l2_write(input logic [31:0] a, input logic [LW-1:0] d, input logic suc,
                          input logic [3:0] strb, input logic [1:0] sz);
    bus.addr_l2cache_mem_w = a; bus.dout_l2cache_mem = d; bus.l2cache_mem_SUC = suc;
    bus.l2cache_mem_wstrb = strb; bus.l2cache_mem_size = sz; bus.l2cache_mem_req_w = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_l2cache_addrOK_w) begin
        step();
        bus.l2cache_mem_req_w = 1'b0;
        return;
      end
    end
    fail_now("write_accept_timeout");
    bus.l2cache_mem_req_w = 1'b0;
  endtask

  // AXI read slave: arready after dly cycles, then n back-to-back beats.
  task automatic axi_read(input int n, input int dly, input logic [31:0] base, input bit abort);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.arvalid;
    end
    if (!seen) begin fail_now("arvalid_timeout"); return; end
    repeat (dly) step();
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    for (int k = 0; k < n; k++) begin
      bus.rvalid = 1'b1; bus.rdata = base + k; bus.rlast = !abort && (k == n - 1);
      step();
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
  endtask

  task automatic l2_consume(input int hold);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_l2cache_dataOK;
    end
    if (!seen) begin fail_now("dataOK_timeout"); return; end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("dataOK_held", bus.mem_l2cache_dataOK, 1'b1);
    end
    step();
    bus.l2cache_mem_rdy = 1'b1;
    step();
    bus.l2cache_mem_rdy = 1'b0;
  endtask

  // AXI write slave: one-cycle awready, wready optionally toggling, bvalid after b_dly.
  task automatic axi_write(input int n, input bit toggle, input int b_dly);
    bit seen = 0;
    bit ph = 0;
    int cnt = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.awvalid;
    end
    if (!seen) begin fail_now("awvalid_timeout"); return; end
    step();
    bus.awready = 1'b1;
    step();
    bus.awready = 1'b0;
    for (int g = 0; g < 100 && cnt < n; g++) begin
      bus.wready = toggle ? ph : 1'b1;
      ph = !ph;
      @(negedge clk);
      if (bus.wvalid && bus.wready) cnt++;
      step();
    end
    bus.wready = 1'b0;
    if (cnt != n) fail_now("wbeat_timeout");
    repeat (b_dly) step();
    bus.bvalid = 1'b1;
    step();
    bus.bvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within 500us");
    $fatal(1, "watchdog expired");
  end

  logic [LW-1:0] t_line;
  bit t_seen;

  initial begin
    bus.addr_l2cache_mem_r = '0; bus.l2cache_mem_req_r = 0; bus.l2cache_mem_rdy = 0;
    bus.addr_l2cache_mem_w = '0; bus.dout_l2cache_mem = '0; bus.l2cache_mem_req_w = 0;
    bus.l2cache_mem_SUC = 0; bus.l2cache_mem_wstrb = '0; bus.l2cache_mem_size = '0;
    bus.arready = 0; bus.rdata = '0; bus.rlast = 0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_valids", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.wlast,
                         bus.bready, bus.mem_l2cache_dataOK}, '0);
    chk("reset_din", bus.din_mem_l2cache, '0);
    step();
    rstn = 1'b0;
    step();

    // Cached read: aligned address, 8 beats, dataOK held 3 cycles
    push_a(0, 32'h1000_0040, 8'd7, 3'd2);
    exp_rd.push_back(mk_line(32'hC0DE_0000));
    l2_read(32'h1000_0044, 1'b0, 2'd2);
    axi_read(8, 2, 32'hC0DE_0000, 1'b0);
    l2_consume(3);

    // Uncached halfword read
    push_a(0, 32'h1FD0_0002, 8'd0, 3'd1);
    exp_rd.push_back({{(LW-32){1'b0}}, 32'h0000_ABCD});
    l2_read(32'h1FD0_0002, 1'b1, 2'd1);
    axi_read(1, 1, 32'h0000_ABCD, 1'b0);
    l2_consume(0);

    // Cached write with toggling wready; buffer busy while in flight
    push_a(1, 32'h2000_0020, 8'd7, 3'd2);
    push_wline(32'hD000_0000);
    l2_write(32'h2000_0020, mk_line(32'hD000_0000), 1'b0, 4'h0, 2'd2);
    fork
      axi_write(8, 1'b1, 2);
      begin
        bus.addr_l2cache_mem_w = 32'h2000_1000;
        bus.l2cache_mem_req_w = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("addrOK_w_busy", bus.mem_l2cache_addrOK_w, 1'b0);
        end
        step();
        bus.l2cache_mem_req_w = 1'b0;
      end
    join

    // Uncached byte write
    push_a(1, 32'h1FD0_0012, 8'd0, 3'd0);
    m_w.data = 32'h1234_5678; m_w.strb = 4'b0100; m_w.last = 1'b1;
    exp_w.push_back(m_w);
    t_line = mk_line(32'hEEEE_0000);
    t_line[31:0] = 32'h1234_5678;
    l2_write(32'h1FD0_0012, t_line, 1'b1, 4'b0100, 2'd0);
    axi_write(1, 1'b0, 0);

    // Read-after-write hazard on line 0x3000_0000
    push_a(1, 32'h3000_0000, 8'd7, 3'd2);
    push_wline(32'hA500_0000);
    push_a(0, 32'h3000_0000, 8'd7, 3'd2);
    exp_rd.push_back(mk_line(32'h5500_0000));
    l2_write(32'h3000_0000, mk_line(32'hA500_0000), 1'b0, 4'h0, 2'd2);
    bus.addr_l2cache_mem_r = 32'h3000_001C; bus.l2cache_mem_SUC = 1'b0; bus.l2cache_mem_req_r = 1'b1;
    fork
      axi_write(8, 1'b0, 3);
      begin
        t_seen = 0;
        for (int i = 0; i < 100 && !t_seen; i++) begin
          @(negedge clk);
          if (bus.bvalid) begin
            t_seen = 1;
            chk("hazard_on_b", bus.mem_l2cache_addrOK_r, 1'b0);
            @(negedge clk);
            chk("hazard_release", bus.mem_l2cache_addrOK_r, 1'b1);
          end else begin
            chk("hazard_stall", bus.mem_l2cache_addrOK_r, 1'b0);
          end
        end
        if (!t_seen) fail_now("hazard_bvalid_timeout");
        step();
        bus.l2cache_mem_req_r = 1'b0;
        @(negedge clk);
        chk("arvalid_after_hazard", bus.arvalid, 1'b1);
      end
    join
    axi_read(8, 1, 32'h5500_0000, 1'b0);
    l2_consume(0);

    // Reset during the read data phase, after 4 beats
    push_a(0, 32'h4000_0000, 8'd7, 3'd2);
    l2_read(32'h4000_0000, 1'b0, 2'd2);
    axi_read(4, 1, 32'h7700_0000, 1'b1);
    rstn = 1'b1;
    step();
    @(negedge clk);
    chk("midreset_valids", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.wlast,
                            bus.bready, bus.mem_l2cache_dataOK}, '0);
    chk("midreset_din", bus.din_mem_l2cache, '0);
    step();
    rstn = 1'b0;
    push_a(0, 32'h5000_0000, 8'd7, 3'd2);
    exp_rd.push_back(mk_line(32'h8800_0000));
    l2_read(32'h5000_0008, 1'b0, 2'd2);
    axi_read(8, 1, 32'h8800_0000, 1'b0);
    l2_consume(1);

    // Simultaneous requests to different lines: both accepted together
    bus.addr_l2cache_mem_r = 32'h6000_0040; bus.l2cache_mem_req_r = 1'b1;
    bus.addr_l2cache_mem_w = 32'h6000_0080; bus.dout_l2cache_mem = mk_line(32'h6600_0000);
    bus.l2cache_mem_SUC = 1'b0; bus.l2cache_mem_req_w = 1'b1;
    push_a(0, 32'h6000_0040, 8'd7, 3'd2);
    exp_rd.push_back(mk_line(32'h9900_0000));
    push_a(1, 32'h6000_0080, 8'd7, 3'd2);
    push_wline(32'h6600_0000);
    @(negedge clk);
    chk("dual_addrOK_r", bus.mem_l2cache_addrOK_r, 1'b1);
    chk("dual_addrOK_w", bus.mem_l2cache_addrOK_w, 1'b1);
    step();
    bus.l2cache_mem_req_r = 1'b0; bus.l2cache_mem_req_w = 1'b0;
    fork
      axi_read(8, 1, 32'h9900_0000, 1'b0);
      axi_write(8, 1'b0, 1);
    join
    l2_consume(0);

    // Simultaneous requests to the same line: write first, read stalls
    bus.addr_l2cache_mem_r = 32'h7000_0010; bus.l2cache_mem_req_r = 1'b1;
    bus.addr_l2cache_mem_w = 32'h7000_0000; bus.dout_l2cache_mem = mk_line(32'h7100_0000);
    bus.l2cache_mem_SUC = 1'b0; bus.l2cache_mem_req_w = 1'b1;
    push_a(1, 32'h7000_0000, 8'd7, 3'd2);
    push_wline(32'h7100_0000);
    push_a(0, 32'h7000_0000, 8'd7, 3'd2);
    exp_rd.push_back(mk_line(32'h7200_0000));
    @(negedge clk);
    chk("same_line_addrOK_w", bus.mem_l2cache_addrOK_w, 1'b1);
    chk("same_line_addrOK_r", bus.mem_l2cache_addrOK_r, 1'b0);
    step();
    bus.l2cache_mem_req_w = 1'b0;
    fork
      axi_write(8, 1'b0, 1);
      l2_read(32'h7000_0010, 1'b0, 2'd2);
    join
    axi_read(8, 1, 32'h7200_0000, 1'b0);
    l2_consume(0);

    repeat (5) step();
    chk("scoreboard_drained", exp_ar.size() + exp_aw.size() + exp_w.size() + exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/l2_axi_bridge.md
Name: l2_axi_bridge

Overview:
- Sits directly downstream of the L1/L2 cache subsystem's L2-Mem port and translates its line-level request/addrOK/dataOK protocol into an AXI4 master.
- Cached requests become 8-beat INCR bursts; SUC (strongly-ordered uncached) requests become single beats.
- Independent read and write engines. Writes are posted through a one-line write buffer, with a read-after-write line hazard check.

Parameters:
offset_width, 3, log2 of words per L2 line; burst length = 2^offset_width beats, arlen/awlen = 2^offset_width-1
LW, 32*(1<<offset_width), line width in bits (derived, not overridable)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-high (rstn=1 resets on the clk edge)
addr_l2cache_mem_r  in  32  read address
l2cache_mem_req_r  in  1  read request
mem_l2cache_addrOK_r  out  1  read request accepted this cycle
din_mem_l2cache  out  LW  read line; uncached result in [31:0], rest zero
mem_l2cache_dataOK  out  1  read data valid; held until l2cache_mem_rdy
l2cache_mem_rdy  in  1  L2 consumes read data
addr_l2cache_mem_w  in  32  write address
dout_l2cache_mem  in  LW  write line; uncached word in [31:0]
l2cache_mem_req_w  in  1  write request
mem_l2cache_addrOK_w  out  1  write accepted (posted) this cycle
l2cache_mem_SUC  in  1  1 = uncached single beat
l2cache_mem_wstrb  in  4  uncached write byte strobes
l2cache_mem_size  in  2  uncached access size (0=B, 1=H, 2=W)
araddr  out  32  AXI read address
arlen  out  8  AXI read burst length
arsize  out  3  AXI read beat size
arburst  out  2  AXI read burst type
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rdata  in  32  AXI read data
rlast  in  1  last read beat
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  32  AXI write address
awlen  out  8  AXI write burst length
awsize  out  3  AXI write beat size
awburst  out  2  AXI write burst type
awvalid  out  1  AXI write address valid
awready  in  1  AXI write address ready
wdata  out  32  AXI write data
wstrb  out  4  AXI write strobes
wlast  out  1  last write beat
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset: both FSMs go to IDLE. All valid/ready/OK outputs, counters and buffers are 0. Reset mid-burst abandons the transaction; the interconnect is reset together with the bridge.
- SUC, wstrb and size are sampled with whichever request is accepted that cycle.
- Read FSM R_IDLE -> R_AR -> R_DATA -> R_DONE -> R_IDLE.
  - mem_l2cache_addrOK_r = req_r & R_IDLE & ~hazard, combinational. The request is latched on that edge.
  - hazard = (write FSM != W_IDLE & line(addr_r) == line(wbuf_addr)) | (req_w & addrOK_w & line(addr_r) == line(addr_w)). line(x) = x[31:offset_width+2].
  - R_AR: arvalid=1, arburst=2'b01.
    - Cached: araddr = line-aligned, arsize=2, arlen=2^offset_width-1.
    - Uncached: araddr = raw addr, arsize={0,size}, arlen=0.
    - Move to R_DATA on arready.
  - R_DATA: rready=1. Each rvalid beat writes word[cnt] and increments cnt. The transaction ends on rvalid&rlast (uncached: first beat). rresp is ignored.
  - R_DONE: dataOK=1 and din_mem_l2cache is stable. Return to R_IDLE on the cycle rdy=1. Read latency ≥ 3 cycles after accept.
- Write FSM W_IDLE -> W_AW -> W_DATA -> W_B -> W_IDLE.
  - mem_l2cache_addrOK_w = req_w & W_IDLE. Address and line are copied into wbuf.
  - W_AW: awvalid=1, with the same address/len/size rules as the read side. Move to W_DATA on awready. W beats never precede the AW handshake.
  - W_DATA: wvalid=1, wdata=wbuf word[cnt]. wstrb = 4'hF when cached, else the latched wstrb. wlast = (cnt==awlen). cnt advances on wready; after the last beat go to W_B.
  - W_B: bready=1. Return to W_IDLE on bvalid; bresp is ignored. The buffer is released only then.
- Simultaneous req_r and req_w to the same line while both engines are idle: the write is accepted and the read is stalled until the write reaches W_IDLE.
- Simultaneous req_r and req_w to different lines: both are accepted the same cycle.
- Counters are offset_width bits wide. There is no wrap past the last beat: the FSM exits first.

Test Plan:
- Cached read 0x1000_0044, arready after 2 cycles, 8 beats 0..7 with rlast on beat 7 -> araddr=0x1000_0040, arlen=7; dataOK with line words 0..7; dataOK held 3 cycles until rdy.
- Uncached read SUC=1 size=1 addr 0x1FD0_0002, rdata 0xABCD -> arlen=0, arsize=1, araddr=0x1FD0_0002; din[31:0]=0xABCD, upper bits 0.
- Cached write 0x2000_0020, wready toggling every other cycle -> awlen=7, 8 beats with wstrb=F and wlast only on beat 8; addrOK_w low until bvalid.
- Uncached write wstrb=4'b0100 -> single beat, wlast=1, wstrb=4'b0100.
- Write to line 0x3000_0000 pending, then read 0x3000_001C -> addrOK_r stays 0 until the cycle after bvalid, then arvalid asserts.
- Reset asserted during R_DATA beat 4 -> next cycle all valids 0, FSMs idle, and a new read is accepted normally.
